// File: rtl/gpio_bank_ctrl_pkg.sv
// Shared definitions for the GPIO bank controller: bus widths, memory request/response
// encodings, register indices and lane helpers.
package gpio_bank_ctrl_pkg;

    localparam int ADDR_W      = 32;
    localparam int WORD_W      = 32;
    localparam int MEM_COUNT_W = 3;
    localparam int MEM_CODE_W  = 3;

    localparam int GPIO_BANK_STRIDE = 32;
    localparam int GPIO_BANK_LSB    = $clog2(GPIO_BANK_STRIDE);

    localparam logic [2:0] GPIO_REG_OUT  = 3'd0;
    localparam logic [2:0] GPIO_REG_DIR  = 3'd1;
    localparam logic [2:0] GPIO_REG_IN   = 3'd2;
    localparam logic [2:0] GPIO_REG_IEN  = 3'd3;
    localparam logic [2:0] GPIO_REG_PEND = 3'd4;

    typedef enum logic [MEM_COUNT_W-1:0] {
        MEM_COUNT_NONE = 3'd0,
        MEM_COUNT_BYTE = 3'd1,
        MEM_COUNT_HALF = 3'd2,
        MEM_COUNT_WORD = 3'd3
    } mem_count_e;

    typedef enum logic [MEM_CODE_W-1:0] {
        MEM_CODE_IDLE       = 3'd0,
        MEM_CODE_READ       = 3'd1,
        MEM_CODE_WRITE      = 3'd2,
        MEM_CODE_INVALID    = 3'd3,
        MEM_CODE_MISALIGNED = 3'd4
    } mem_code_e;

    // Expand a 4-bit byte-lane mask into a 32-bit bit mask.
    function automatic logic [31:0] lane_bits(input logic [3:0] lanes);
        logic [31:0] bits;
        for (int i = 0; i < 4; i++) begin
            bits[8*i +: 8] = {8{lanes[i]}};
        end
        return bits;
    endfunction

    // Registers 5..7 do not exist and IN cannot be written.
    function automatic logic reg_access_ok(input logic [2:0] idx, input logic is_write);
        logic ok;
        if (idx > GPIO_REG_PEND) begin
            ok = 1'b0;
        end else if (is_write && (idx == GPIO_REG_IN)) begin
            ok = 1'b0;
        end else begin
            ok = 1'b1;
        end
        return ok;
    endfunction

    // Replace only the bits selected by mask.
    function automatic logic [31:0] merge_lanes(input logic [31:0] old_val,
                                                input logic [31:0] new_val,
                                                input logic [31:0] mask);
        return (old_val & ~mask) | (new_val & mask);
    endfunction

endpackage

// File: rtl/gpio_sync_edge.sv
// Per-bank pad input synchroniser with a registered previous value for 0->1 detection.
module gpio_sync_edge
#(
    parameter int SYNC_STAGES = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] pins,
    output logic [31:0] synced,
    output logic [31:0] rise
);

    logic [31:0] stage_r [SYNC_STAGES];
    logic [31:0] prev_r;

    // Synchroniser chain plus the previous synchronised value
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < SYNC_STAGES; i++) begin
                stage_r[i] <= 32'h0;
            end
            prev_r <= 32'h0;
        end else begin
            stage_r[0] <= pins;
            for (int i = 1; i < SYNC_STAGES; i++) begin
                stage_r[i] <= stage_r[i-1];
            end
            prev_r <= stage_r[SYNC_STAGES-1];
        end
    end

    assign synced = stage_r[SYNC_STAGES-1];
    assign rise   = stage_r[SYNC_STAGES-1] & ~prev_r;

endmodule

// File: rtl/gpio_bank_ctrl.sv
// GPIO bank controller: memory-mapped OUT/DIR/IN/IEN/PEND registers per 32-bit bank,
// single-cycle registered responses and a rising-edge interrupt.
module gpio_bank_ctrl
    import gpio_bank_ctrl_pkg::*;
#(
    parameter int N_BANKS     = 2,
    parameter int SYNC_STAGES = 2
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [ADDR_W-1:0]       i_req_addr,
    input  logic [WORD_W-1:0]       i_req_wr_data,
    input  logic                    i_req_wr_en,
    input  logic [MEM_COUNT_W-1:0]  i_req_count,
    output logic [WORD_W-1:0]       o_res_rd_data,
    output logic [MEM_CODE_W-1:0]   o_res_code,
    input  logic [N_BANKS*32-1:0]   i_gpio_in,
    output logic [N_BANKS*32-1:0]   o_gpio_out,
    output logic [N_BANKS*32-1:0]   o_gpio_oe,
    output logic                    o_irq
);

    localparam int BANK_W = (N_BANKS > 1) ? $clog2(N_BANKS) : 1;

    logic [31:0]        out_r      [N_BANKS];
    logic [31:0]        dir_r      [N_BANKS];
    logic [31:0]        ien_r      [N_BANKS];
    logic [31:0]        pend_r     [N_BANKS];
    logic [31:0]        sync_s     [N_BANKS];
    logic [31:0]        rise_s     [N_BANKS];
    logic [31:0]        pend_clr_s [N_BANKS];

    logic [BANK_W-1:0]  bank_s;
    logic [2:0]         reg_s;
    logic [1:0]         off_s;
    logic [3:0]         lanes_s;
    logic [31:0]        bits_s;
    logic [31:0]        wr_shift_s;
    logic [31:0]        sel_val_s;
    logic [WORD_W-1:0]  rd_data_s;
    logic               count_ok_s;
    logic               aligned_s;
    logic               wr_ok_s;
    logic               irq_s;
    mem_code_e          code_s;

    logic [WORD_W-1:0]  rd_data_r;
    mem_code_e          code_r;
    logic               irq_r;
    logic               unused_addr_s;

    assign reg_s      = i_req_addr[4:2];
    assign off_s      = i_req_addr[1:0];
    assign bits_s     = lane_bits(lanes_s);
    assign wr_shift_s = i_req_wr_data << {off_s, 3'b000};

    generate
        if (N_BANKS > 1) begin : g_bank_sel
            assign bank_s        = i_req_addr[GPIO_BANK_LSB +: BANK_W];
            assign unused_addr_s = ^i_req_addr[ADDR_W-1:GPIO_BANK_LSB+BANK_W];
        end else begin : g_bank_one
            assign bank_s        = 1'b0;
            assign unused_addr_s = ^i_req_addr[ADDR_W-1:GPIO_BANK_LSB];
        end

        for (genvar b = 0; b < N_BANKS; b++) begin : g_bank
            gpio_sync_edge #(
                .SYNC_STAGES (SYNC_STAGES)
            ) u_sync_edge (
                .clk    (clk),
                .reset  (reset),
                .pins   (i_gpio_in[32*b +: 32]),
                .synced (sync_s[b]),
                .rise   (rise_s[b])
            );

            assign o_gpio_out[32*b +: 32] = out_r[b];
            assign o_gpio_oe[32*b +: 32]  = dir_r[b];
        end
    endgenerate

    // Access size to byte lanes and alignment; NONE and unencoded sizes are rejected
    always_comb begin
        count_ok_s = 1'b1;
        aligned_s  = 1'b1;
        lanes_s    = 4'b0000;
        case (i_req_count)
            MEM_COUNT_BYTE: begin
                lanes_s = 4'b0001 << off_s;
            end
            MEM_COUNT_HALF: begin
                lanes_s   = 4'b0011 << off_s;
                aligned_s = ~off_s[0];
            end
            MEM_COUNT_WORD: begin
                lanes_s   = 4'b1111;
                aligned_s = (off_s == 2'd0);
            end
            default: begin
                count_ok_s = 1'b0;
            end
        endcase
    end

    // Read mux; IN and PEND present their pre-edge values
    always_comb begin
        sel_val_s = 32'h0;
        case (reg_s)
            GPIO_REG_OUT:  sel_val_s = out_r[bank_s];
            GPIO_REG_DIR:  sel_val_s = dir_r[bank_s];
            GPIO_REG_IN:   sel_val_s = sync_s[bank_s];
            GPIO_REG_IEN:  sel_val_s = ien_r[bank_s];
            GPIO_REG_PEND: sel_val_s = pend_r[bank_s];
            default:       sel_val_s = 32'h0;
        endcase
    end

    // Response classification: misalignment is checked before register validity
    always_comb begin
        code_s    = MEM_CODE_INVALID;
        rd_data_s = '0;
        wr_ok_s   = 1'b0;
        if (!count_ok_s) begin
            code_s = MEM_CODE_INVALID;
        end else if (!aligned_s) begin
            code_s = MEM_CODE_MISALIGNED;
        end else if (!reg_access_ok(reg_s, i_req_wr_en)) begin
            code_s = MEM_CODE_INVALID;
        end else if (i_req_wr_en) begin
            code_s  = MEM_CODE_WRITE;
            wr_ok_s = 1'b1;
        end else begin
            code_s    = MEM_CODE_READ;
            rd_data_s = (sel_val_s & bits_s) >> {off_s, 3'b000};
        end
    end

    // Per-bank write-1-to-clear mask for PEND
    always_comb begin
        for (int b = 0; b < N_BANKS; b++) begin
            pend_clr_s[b] = 32'h0;
            if (wr_ok_s && (bank_s == BANK_W'(b)) && (reg_s == GPIO_REG_PEND)) begin
                pend_clr_s[b] = wr_shift_s & bits_s;
            end else begin
                pend_clr_s[b] = 32'h0;
            end
        end
    end

    // Interrupt request before registering
    always_comb begin
        irq_s = 1'b0;
        for (int b = 0; b < N_BANKS; b++) begin
            irq_s = irq_s | (|(pend_r[b] & ien_r[b]));
        end
    end

    // Register file, pending bits and response/interrupt registers
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int b = 0; b < N_BANKS; b++) begin
                out_r[b]  <= 32'h0;
                dir_r[b]  <= 32'h0;
                ien_r[b]  <= 32'h0;
                pend_r[b] <= 32'h0;
            end
            rd_data_r <= '0;
            code_r    <= MEM_CODE_IDLE;
            irq_r     <= 1'b0;
        end else begin
            rd_data_r <= rd_data_s;
            code_r    <= code_s;
            irq_r     <= irq_s;
            for (int b = 0; b < N_BANKS; b++) begin
                if (wr_ok_s && (bank_s == BANK_W'(b))) begin
                    case (reg_s)
                        GPIO_REG_OUT: out_r[b] <= merge_lanes(out_r[b], wr_shift_s, bits_s);
                        GPIO_REG_DIR: dir_r[b] <= merge_lanes(dir_r[b], wr_shift_s, bits_s);
                        GPIO_REG_IEN: ien_r[b] <= merge_lanes(ien_r[b], wr_shift_s, bits_s);
                        default: ;
                    endcase
                end
                // A new edge outranks a simultaneous clear
                pend_r[b] <= (pend_r[b] & ~pend_clr_s[b]) | (rise_s[b] & ien_r[b]);
            end
        end
    end

    assign o_res_rd_data = rd_data_r;
    assign o_res_code    = code_r;
    assign o_irq         = irq_r;

endmodule

// File: tb/tb_gpio_bank_ctrl.sv
// Self-checking bench for gpio_bank_ctrl: directed vector table, hand-written edge/reset
// sequences and randomized traffic against a behavioural model.
module tb_gpio_bank_ctrl;
    import gpio_bank_ctrl_pkg::*;

    localparam int NB = 2;
    localparam int SS = 3;
    localparam int GW = NB * 32;

    logic                   clk = 1'b0;
    logic                   reset;
    logic [ADDR_W-1:0]      addr;
    logic [WORD_W-1:0]      wdata;
    logic                   wr;
    logic [MEM_COUNT_W-1:0] cnt;
    logic [WORD_W-1:0]      rd;
    logic [MEM_CODE_W-1:0]  code;
    logic [GW-1:0]          pins;
    logic [GW-1:0]          gout;
    logic [GW-1:0]          goe;
    logic                   irq;

    gpio_bank_ctrl #(.N_BANKS(NB), .SYNC_STAGES(SS)) dut (
        .clk           (clk),
        .reset         (reset),
        .i_req_addr    (addr),
        .i_req_wr_data (wdata),
        .i_req_wr_en   (wr),
        .i_req_count   (cnt),
        .o_res_rd_data (rd),
        .o_res_code    (code),
        .i_gpio_in     (pins),
        .o_gpio_out    (gout),
        .o_gpio_oe     (goe),
        .o_irq         (irq)
    );

    always #5 clk = ~clk;

    int n_cmp  = 0;
    int n_fail = 0;

    // Behavioural model state
    logic [31:0]   out_m  [NB];
    logic [31:0]   dir_m  [NB];
    logic [31:0]   ien_m  [NB];
    logic [31:0]   pend_m [NB];
    logic [GW-1:0] syn_cur;
    logic [GW-1:0] syn_prev;
    logic [GW-1:0] hist [$];
    logic [2:0]    exp_code;
    logic [31:0]   exp_data;
    logic          exp_irq;

    typedef struct {
        logic [31:0] a;
        logic [31:0] d;
        logic        w;
        logic [2:0]  c;
        logic [2:0]  ecode;
        logic [31:0] edata;
    } vec_t;

    vec_t tbl [19];

    task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] reg_val(input int rg, input int bk);
        case (rg)
            0:       return out_m[bk];
            1:       return dir_m[bk];
            2:       return syn_cur[32*bk +: 32];
            3:       return ien_m[bk];
            4:       return pend_m[bk];
            default: return 32'h0;
        endcase
    endfunction

    // Advance the model by one clock edge using the currently applied inputs
    task automatic model_edge();
        logic [31:0]   pend_pre [NB];
        logic [31:0]   ien_pre  [NB];
        logic [31:0]   val;
        logic [31:0]   clr;
        logic [31:0]   rise;
        logic [63:0]   wide;
        logic [GW-1:0] syn_new;
        logic          pend_w;
        int nb, off, rg, bk;
        if (reset) begin
            for (int b = 0; b < NB; b++) begin
                out_m[b] = 32'h0; dir_m[b] = 32'h0; ien_m[b] = 32'h0; pend_m[b] = 32'h0;
            end
            syn_cur = '0; syn_prev = '0;
            hist.delete();
            for (int i = 0; i < SS - 1; i++) hist.push_back('0);
            exp_code = 3'd0; exp_data = 32'h0; exp_irq = 1'b0;
            return;
        end
        exp_irq = 1'b0;
        for (int b = 0; b < NB; b++) begin
            pend_pre[b] = pend_m[b];
            ien_pre[b]  = ien_m[b];
            if ((pend_pre[b] & ien_pre[b]) != 32'h0) exp_irq = 1'b1;
        end
        case (cnt)
            3'd1:    nb = 1;
            3'd2:    nb = 2;
            3'd3:    nb = 4;
            default: nb = 0;
        endcase
        off = int'(addr[1:0]);
        rg  = int'(addr[4:2]);
        bk  = int'(addr >> 5) % NB;
        exp_data = 32'h0;
        clr = 32'h0;
        pend_w = 1'b0;
        if (nb == 0) begin
            exp_code = MEM_CODE_INVALID;
        end else if ((off % nb) != 0) begin
            exp_code = MEM_CODE_MISALIGNED;
        end else if (rg > 4 || (wr && rg == 2)) begin
            exp_code = MEM_CODE_INVALID;
        end else if (wr) begin
            exp_code = MEM_CODE_WRITE;
            val = reg_val(rg, bk);
            for (int i = 0; i < nb; i++) begin
                val[8*(off+i) +: 8] = wdata[8*i +: 8];
                clr[8*(off+i) +: 8] = wdata[8*i +: 8];
            end
            case (rg)
                0: out_m[bk] = val;
                1: dir_m[bk] = val;
                3: ien_m[bk] = val;
                4: pend_w = 1'b1;
                default: ;
            endcase
        end else begin
            exp_code = MEM_CODE_READ;
            wide = {32'h0, reg_val(rg, bk)} >> (8 * off);
            exp_data = (nb == 4) ? wide[31:0] : (wide[31:0] & ((32'h1 << (8 * nb)) - 32'h1));
        end
        for (int b = 0; b < NB; b++) begin
            rise = syn_cur[32*b +: 32] & ~syn_prev[32*b +: 32];
            pend_m[b] = (pend_pre[b] & ~((pend_w && b == bk) ? clr : 32'h0)) | (rise & ien_pre[b]);
        end
        hist.push_back(pins);
        syn_new  = hist.pop_front();
        syn_prev = syn_cur;
        syn_cur  = syn_new;
    endtask

    task automatic cycle(input logic rst, input logic [31:0] a, input logic w,
                         input logic [2:0] c, input logic [31:0] d);
        logic [GW-1:0] eo, ee;
        reset = rst; addr = a; wr = w; cnt = c; wdata = d;
        @(posedge clk);
        model_edge();
        #1;
        for (int b = 0; b < NB; b++) begin
            eo[32*b +: 32] = out_m[b];
            ee[32*b +: 32] = dir_m[b];
        end
        chk("code", code, exp_code);
        chk("rd_data", rd, exp_data);
        chk("irq", irq, exp_irq);
        chk("gpio_out", gout, eo);
        chk("gpio_oe", goe, ee);
    endtask

    initial begin
        logic [31:0] a;
        int r;

        tbl[0]  = '{32'h20, 32'hA5A50F0F, 1'b1, MEM_COUNT_WORD, MEM_CODE_WRITE,      32'h0};
        tbl[1]  = '{32'h20, 32'h0,        1'b0, MEM_COUNT_WORD, MEM_CODE_READ,       32'hA5A50F0F};
        tbl[2]  = '{32'h00, 32'h0,        1'b0, MEM_COUNT_WORD, MEM_CODE_READ,       32'h0};
        tbl[3]  = '{32'h25, 32'h3C,       1'b1, MEM_COUNT_BYTE, MEM_CODE_WRITE,      32'h0};
        tbl[4]  = '{32'h25, 32'h0,        1'b0, MEM_COUNT_BYTE, MEM_CODE_READ,       32'h3C};
        tbl[5]  = '{32'h24, 32'h0,        1'b0, MEM_COUNT_WORD, MEM_CODE_READ,       32'h3C00};
        tbl[6]  = '{32'h01, 32'h0,        1'b0, MEM_COUNT_HALF, MEM_CODE_MISALIGNED, 32'h0};
        tbl[7]  = '{32'h08, 32'hFFFFFFFF, 1'b1, MEM_COUNT_WORD, MEM_CODE_INVALID,    32'h0};
        tbl[8]  = '{32'h14, 32'h0,        1'b0, MEM_COUNT_WORD, MEM_CODE_INVALID,    32'h0};
        tbl[9]  = '{32'h00, 32'h0,        1'b0, MEM_COUNT_NONE, MEM_CODE_INVALID,    32'h0};
        tbl[10] = '{32'h00, 32'h0,        1'b0, 3'd5,           MEM_CODE_INVALID,    32'h0};
        tbl[11] = '{32'h22, 32'h0,        1'b0, MEM_COUNT_HALF, MEM_CODE_READ,       32'hA5A5};
        tbl[12] = '{32'h21, 32'hFF,       1'b1, MEM_COUNT_WORD, MEM_CODE_MISALIGNED, 32'h0};
        tbl[13] = '{32'h23, 32'h0,        1'b0, MEM_COUNT_BYTE, MEM_CODE_READ,       32'hA5};
        tbl[14] = '{32'h60, 32'h0,        1'b0, MEM_COUNT_WORD, MEM_CODE_READ,       32'hA5A50F0F};
        tbl[15] = '{32'h1C, 32'h1,        1'b1, MEM_COUNT_WORD, MEM_CODE_INVALID,    32'h0};
        tbl[16] = '{32'h2E, 32'hBEEF,     1'b1, MEM_COUNT_HALF, MEM_CODE_WRITE,      32'h0};
        tbl[17] = '{32'h2C, 32'h0,        1'b0, MEM_COUNT_WORD, MEM_CODE_READ,       32'hBEEF0000};
        tbl[18] = '{32'h28, 32'h0,        1'b0, MEM_COUNT_WORD, MEM_CODE_READ,       32'h0};

        pins = '0;
        cycle(1'b1, 32'h0, 1'b0, MEM_COUNT_NONE, 32'h0);
        cycle(1'b1, 32'h0, 1'b0, MEM_COUNT_NONE, 32'h0);
        chk("reset_code", code, 3'd0);
        chk("reset_out", gout, '0);

        for (int i = 0; i < 19; i++) begin
            cycle(1'b0, tbl[i].a, tbl[i].w, tbl[i].c, tbl[i].d);
            chk($sformatf("tbl%0d_code", i), code, tbl[i].ecode);
            chk($sformatf("tbl%0d_data", i), rd, tbl[i].edata);
        end
        chk("bank1_out", gout[63:32], 32'hA5A50F0F);
        chk("bank0_out", gout[31:0], 32'h0);
        chk("bank1_oe", goe[63:32], 32'h00003C00);

        // Edge to PEND to IRQ, then W1C
        cycle(1'b1, 32'h0, 1'b0, MEM_COUNT_NONE, 32'h0);
        cycle(1'b0, 32'h0C, 1'b1, MEM_COUNT_WORD, 32'h1);
        pins[0] = 1'b1;
        for (int k = 0; k <= SS; k++) begin
            cycle(1'b0, 32'h0, 1'b0, MEM_COUNT_NONE, 32'h0);
            chk("irq_quiet", irq, 1'b0);
        end
        cycle(1'b0, 32'h10, 1'b0, MEM_COUNT_WORD, 32'h0);
        chk("pend_set", rd, 32'h1);
        chk("irq_rise", irq, 1'b1);
        cycle(1'b0, 32'h10, 1'b1, MEM_COUNT_WORD, 32'h1);
        chk("w1c_code", code, MEM_CODE_WRITE);
        chk("irq_hold", irq, 1'b1);
        cycle(1'b0, 32'h10, 1'b0, MEM_COUNT_WORD, 32'h0);
        chk("pend_clr", rd, 32'h0);
        chk("irq_fall", irq, 1'b0);

        // W1C coinciding with a fresh edge: set wins
        pins[0] = 1'b0;
        for (int k = 0; k <= SS; k++) cycle(1'b0, 32'h0, 1'b0, MEM_COUNT_NONE, 32'h0);
        pins[0] = 1'b1;
        for (int k = 0; k < SS; k++) cycle(1'b0, 32'h0, 1'b0, MEM_COUNT_NONE, 32'h0);
        cycle(1'b0, 32'h10, 1'b1, MEM_COUNT_WORD, 32'h1);
        cycle(1'b0, 32'h10, 1'b0, MEM_COUNT_WORD, 32'h0);
        chk("set_wins", rd, 32'h1);

        // Reset in the middle of traffic
        cycle(1'b0, 32'h04, 1'b1, MEM_COUNT_WORD, 32'hFF);
        cycle(1'b0, 32'h00, 1'b1, MEM_COUNT_WORD, 32'hFFFFFFFF);
        chk("out_ones", gout[31:0], 32'hFFFFFFFF);
        cycle(1'b1, 32'h00, 1'b1, MEM_COUNT_WORD, 32'h12345678);
        chk("rst_code", code, 3'd0);
        chk("rst_data", rd, 32'h0);
        chk("rst_irq", irq, 1'b0);
        chk("rst_out", gout, '0);
        chk("rst_oe", goe, '0);
        cycle(1'b0, 32'h00, 1'b0, MEM_COUNT_WORD, 32'h0);
        chk("post_rst_read", code, MEM_CODE_READ);
        chk("post_rst_out", rd, 32'h0);

        // Randomized traffic
        for (int n = 0; n < 3000; n++) begin
            pins = pins ^ {$urandom & $urandom & $urandom, $urandom & $urandom & $urandom};
            a = $urandom;
            a[4:2] = 3'($urandom_range(0, 5));
            if ($urandom_range(0, 1) == 0) a[1:0] = 2'b00;
            r = $urandom_range(0, 9);
            cycle(($urandom_range(0, 249) == 0), a, 1'($urandom_range(0, 1)),
                  (r == 0 || r == 9) ? 3'd0 : (r <= 2) ? 3'd1 : (r <= 4) ? 3'd2 :
                  (r <= 7) ? 3'd3 : 3'($urandom_range(4, 7)),
                  $urandom);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/gpio_bank_ctrl.md
GPIO_BANK_CTRL -- requirements
Module: gpio_bank_ctrl

Interface
REQ-001 SHALL have parameter N_BANKS, default 2: number of 32-bit GPIO banks, power of two, 1..8.
REQ-002 SHALL have parameter SYNC_STAGES, default 2: input synchroniser depth, 2..4.
REQ-003 SHALL have clk  input  1: single clock; one clock, all state on posedge clk.
REQ-004 SHALL have reset  input  1: synchronous, active-high reset.
REQ-005 SHALL have i_req_addr  input  ADDR_W: byte address of request.
REQ-006 SHALL have i_req_wr_data  input  WORD_W: write data, LSB-aligned.
REQ-007 SHALL have i_req_wr_en  input  1: 1 = write, 0 = read.
REQ-008 SHALL have i_req_count  input  MEM_COUNT_W: none/byte/half/word.
REQ-009 SHALL have o_res_rd_data  output  WORD_W: registered read data, zero-extended.
REQ-010 SHALL have o_res_code  output  MEM_CODE_W: registered response code.
REQ-011 SHALL have i_gpio_in  input  N_BANKS*32: asynchronous pad inputs; bank b occupies bits [32b+31:32b].
REQ-012 SHALL have o_gpio_out  output  N_BANKS*32: output data, bank b at bits [32b+31:32b].
REQ-013 SHALL have o_gpio_oe  output  N_BANKS*32: per-pin output enable, where 1 = drive.
REQ-014 SHALL have o_irq  output  1: registered OR of (PEND & IEN) over all banks.

Function
REQ-015 SHALL decode the register map: bank = addr[5 +: log2(N_BANKS)], reg = addr[4:2], byte offset = addr[1:0], higher bits ignored (aliased).
REQ-016 SHALL implement per-bank registers: reg0 OUT (RW), reg1 DIR (RW, drives o_gpio_oe), reg2 IN (RO, synchronised pins), reg3 IEN (RW), reg4 PEND (read; write-1-to-clear); reg5..7 are invalid.
REQ-017 SHALL produce a response exactly one cycle after the request; no back-pressure; one request accepted per cycle.
REQ-018 SHALL, when i_req_count = NONE, drive code INVALID and data 0 on the next cycle with no state change.
REQ-019 SHALL flag misalignment (half with offset[0]≠0, word with offset≠0) as MISALIGNED with data 0, ahead of all other checks, with no state change.
REQ-020 SHALL answer a write to IN or to reg5..7, or a read of reg5..7, with INVALID, data 0, and no state change; an unknown count value also yields INVALID.
REQ-021 SHALL, on a valid write, update only the addressed byte lanes and return code WRITE with data 0; for PEND, bits set in the addressed lanes clear the matching pending bits.
REQ-022 SHALL, on a valid read, return the addressed lanes shifted to bit 0 and zero-extended, with code READ.
REQ-023 SHALL synchronise i_gpio_in through SYNC_STAGES flops; IN reflects the last synchroniser stage.
REQ-024 SHALL set a PEND bit in the cycle its synchronised input shows a 0→1 transition while the corresponding IEN bit = 1; edges with IEN = 0 are discarded.
REQ-025 SHALL, when a PEND bit sees a set and a W1C in the same cycle, leave the bit at 1 (set wins).
REQ-026 SHALL update o_irq one cycle after PEND/IEN change.
REQ-027 SHALL give a read of IN or PEND the value held before that cycle's edge update.

Reset
REQ-028 SHALL, while reset = 1 at posedge clk, clear OUT, DIR, IEN, PEND, all synchroniser and edge flops, o_res_rd_data, o_res_code and o_irq to 0.
REQ-029 SHALL abandon a request arriving during reset with no response; the first post-reset cycle outputs code 0.
REQ-030 SHALL detect no edge on the first post-reset cycle for a pin already high, because the previous-value flop resets to 0 and the synchroniser is also cleared; the edge appears after SYNC_STAGES cycles.

Structure
REQ-031 SHALL place register-index constants (GPIO_REG_OUT=0, DIR=1, IN=2, IEN=3, PEND=4) and the bank stride (32 bytes) in shared header gpio_regs.vh; ADDR_W, WORD_W and MEM codes come from config.vh and mem_codes.vh.
REQ-032 SHALL instantiate sub-module gpio_sync_edge (parameter SYNC_STAGES; one 32-bit bank; outputs synced value and rising-edge pulse) once per bank via generate.

Verification
REQ-033 SHALL cover: word write 0xA5A5_0F0F to bank1 OUT (addr 0x20) → code WRITE; o_gpio_out[63:32]=0xA5A5_0F0F next cycle; bank0 unchanged.
REQ-034 SHALL cover: byte write 0x3C to addr 0x25 (bank1 DIR, lane1) → DIR1=0x0000_3C00; byte read of addr 0x25 → data 0x0000_003C, code READ.
REQ-035 SHALL cover: half read at addr 0x01 → MISALIGNED, data 0; word write to addr 0x08 (IN) → INVALID; addr 0x14 (reg5) → INVALID.
REQ-036 SHALL cover: IEN0=0x1, i_gpio_in[0] rising → PEND0[0]=1 after SYNC_STAGES+1 cycles, o_irq=1 one cycle later; write 0x1 to addr 0x10 → PEND clears, o_irq falls the following cycle.
REQ-037 SHALL cover: W1C to PEND0 coinciding with a new edge on bit 0 → PEND0[0] remains 1.
REQ-038 SHALL cover: reset asserted mid-request with OUT=0xFFFF_FFFF → all outputs 0 next cycle; first post-reset response code 0.
